vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parameterised VGA raster timing generator. Free-running
//                horizontal/vertical counters advance on a pixel-rate enable.
//                nextX/nextY give the pixel to fetch now. blank_n, hSync and
//                vSync are registered one enable later, which absorbs one
//                cycle of pixel-source latency. lineStart and frameStart
//                mark that registered position.
//                Optional feature macro: VGA_FRAME_COUNTER_EN adds a 16-bit
//                frameCount output.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int X_WIDTH    = 11,
    parameter int Y_WIDTH    = 10
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               PixelEn,
    output logic [X_WIDTH-1:0] nextX,
    output logic [Y_WIDTH-1:0] nextY,
    output logic               blank_n,
    output logic               hSync,
    output logic               vSync,
    output logic               sync_n,
    output logic               lineStart,
    output logic               frameStart
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [15:0]        frameCount
`endif
);

    localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Refuse configurations with an empty region or counters too narrow.
    if (H_VISIBLE <= 0 || H_FRONT <= 0 || H_SYNC <= 0 || H_BACK <= 0) begin : g_bad_h_region
        $error("vga_timing_gen: every horizontal region must be non-empty");
    end
    if (V_VISIBLE <= 0 || V_FRONT <= 0 || V_SYNC <= 0 || V_BACK <= 0) begin : g_bad_v_region
        $error("vga_timing_gen: every vertical region must be non-empty");
    end
    if (X_WIDTH < 1 || X_WIDTH > 30 || c_h_total > (1 << X_WIDTH)) begin : g_bad_x_width
        $error("vga_timing_gen: X_WIDTH too small for H_TOTAL");
    end
    if (Y_WIDTH < 1 || Y_WIDTH > 30 || c_v_total > (1 << Y_WIDTH)) begin : g_bad_y_width
        $error("vga_timing_gen: Y_WIDTH too small for V_TOTAL");
    end

    localparam logic [X_WIDTH-1:0] c_h_last     = X_WIDTH'(c_h_total - 1);
    localparam logic [X_WIDTH-1:0] c_h_vis      = X_WIDTH'(H_VISIBLE);
    localparam logic [X_WIDTH-1:0] c_hs_start   = X_WIDTH'(H_VISIBLE + H_FRONT);
    localparam logic [X_WIDTH-1:0] c_hs_end     = X_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [Y_WIDTH-1:0] c_v_last     = Y_WIDTH'(c_v_total - 1);
    localparam logic [Y_WIDTH-1:0] c_v_vis      = Y_WIDTH'(V_VISIBLE);
    localparam logic [Y_WIDTH-1:0] c_vs_start   = Y_WIDTH'(V_VISIBLE + V_FRONT);
    localparam logic [Y_WIDTH-1:0] c_vs_end     = Y_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [X_WIDTH-1:0] r_h_count;
    logic [Y_WIDTH-1:0] r_v_count;
    logic               r_blank_n;
    logic               r_h_sync;
    logic               r_v_sync;
    logic               r_line_start;
    logic               r_frame_start;

    logic w_h_last;
    logic w_v_last;
    logic w_visible;
    logic w_h_in_sync;
    logic w_v_in_sync;
    logic w_line_origin;
    logic w_frame_origin;

    assign w_h_last       = (r_h_count == c_h_last);
    assign w_v_last       = (r_v_count == c_v_last);
    assign w_visible      = (r_h_count < c_h_vis) && (r_v_count < c_v_vis);
    assign w_h_in_sync    = (r_h_count >= c_hs_start) && (r_h_count < c_hs_end);
    assign w_v_in_sync    = (r_v_count >= c_vs_start) && (r_v_count < c_vs_end);
    assign w_line_origin  = (r_h_count == '0);
    assign w_frame_origin = w_line_origin && (r_v_count == '0);

    // Fetch coordinates follow the live counters and read zero in blanking.
    assign nextX = w_visible ? r_h_count : '0;
    assign nextY = w_visible ? r_v_count : '0;

    // Raster position counters; both wrap together at the last pixel of a frame.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_h_count <= '0;
            r_v_count <= '0;
        end else if (PixelEn) begin
            if (w_h_last) begin
                r_h_count <= '0;
                r_v_count <= w_v_last ? '0 : r_v_count + Y_WIDTH'(1);
            end else begin
                r_h_count <= r_h_count + X_WIDTH'(1);
            end
        end
    end

    // Monitor controls lag the fetch position by one enable; markers last one clock.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_blank_n     <= 1'b0;
            r_h_sync      <= ~H_SYNC_POL;
            r_v_sync      <= ~V_SYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (PixelEn) begin
            r_blank_n     <= w_visible;
            r_h_sync      <= w_h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
            r_v_sync      <= w_v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
            r_line_start  <= w_line_origin;
            r_frame_start <= w_frame_origin;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign blank_n    = r_blank_n;
    assign hSync      = r_h_sync;
    assign vSync      = r_v_sync;
    assign sync_n     = 1'b0;
    assign lineStart  = r_line_start;
    assign frameStart = r_frame_start;

`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] r_frame_count;

    // Steps on the same edge that raises frameStart, wrapping naturally at 16 bits.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_frame_count <= '0;
        end else if (PixelEn && w_frame_origin) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frameCount = r_frame_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Directed self-checking bench for vga_timing_gen. Drives a
//                default 640x480 instance, a positive-hsync 800-wide instance
//                and a tiny raster instance from one clock/reset/enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic PixelEn = 1'b0;

    always #5 Clock = ~Clock;

    // Default 640x480 timing
    logic [10:0] a_x;
    logic [9:0]  a_y;
    logic        a_blank_n, a_hs, a_vs, a_sync_n, a_ls, a_fs;
    // 800-wide line, active-high hsync
    logic [10:0] b_x;
    logic [9:0]  b_y;
    logic        b_blank_n, b_hs, b_vs, b_sync_n, b_ls, b_fs;
    // Tiny raster: 15 pixels x 8 lines, frame of 120 enables
    logic [3:0]  c_x;
    logic [2:0]  c_y;
    logic        c_blank_n, c_hs, c_vs, c_sync_n, c_ls, c_fs;
`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] a_fc, b_fc, c_fc;
`endif

    vga_timing_gen u_a (
        .Clock(Clock), .Reset(Reset), .PixelEn(PixelEn),
        .nextX(a_x), .nextY(a_y), .blank_n(a_blank_n), .hSync(a_hs), .vSync(a_vs),
        .sync_n(a_sync_n), .lineStart(a_ls), .frameStart(a_fs)
`ifdef VGA_FRAME_COUNTER_EN
        , .frameCount(a_fc)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88), .H_SYNC_POL(1'b1)
    ) u_b (
        .Clock(Clock), .Reset(Reset), .PixelEn(PixelEn),
        .nextX(b_x), .nextY(b_y), .blank_n(b_blank_n), .hSync(b_hs), .vSync(b_vs),
        .sync_n(b_sync_n), .lineStart(b_ls), .frameStart(b_fs)
`ifdef VGA_FRAME_COUNTER_EN
        , .frameCount(b_fc)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .X_WIDTH(4), .Y_WIDTH(3)
    ) u_c (
        .Clock(Clock), .Reset(Reset), .PixelEn(PixelEn),
        .nextX(c_x), .nextY(c_y), .blank_n(c_blank_n), .hSync(c_hs), .vSync(c_vs),
        .sync_n(c_sync_n), .lineStart(c_ls), .frameStart(c_fs)
`ifdef VGA_FRAME_COUNTER_EN
        , .frameCount(c_fc)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    int a_hs_low, a_hs_first, a_hs_last, a_ls_cnt;
    int b_hs_high, b_hs_first, b_hs_last;
    int c_fs_cnt, c_ls_cnt, c_vs_low, c_vs_first, c_ls_pulses;

    initial begin
        a_hs_low = 0; a_hs_first = -1; a_hs_last = -1; a_ls_cnt = 0;
        b_hs_high = 0; b_hs_first = -1; b_hs_last = -1;
        c_fs_cnt = 0; c_ls_cnt = 0; c_vs_low = 0; c_vs_first = -1; c_ls_pulses = 0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_blank_n", a_blank_n, 0);
        chk("rst_hsync",   a_hs, 1);
        chk("rst_vsync",   a_vs, 1);
        chk("rst_hsync_b", b_hs, 0);
        chk("rst_ls",      a_ls, 0);
        chk("rst_fs",      a_fs, 0);
        chk("rst_nextx",   a_x, 0);
        chk("rst_nexty",   a_y, 0);
        chk("sync_n",      a_sync_n, 0);

        // Release with constant enable; k counts enabled edges since release
        Reset = 1'b1;
        PixelEn = 1'b1;
        for (int k = 1; k <= 1060; k++) begin
            tick();
            if (k == 1) begin
                chk("k1_fs", a_fs, 1);
                chk("k1_ls", a_ls, 1);
                chk("k1_blank_n", a_blank_n, 1);
                chk("k1_nextx", a_x, 1);
                chk("k1_nexty", a_y, 0);
                chk("k1_hsync", a_hs, 1);
            end
            if (k == 2) begin
                chk("k2_fs", a_fs, 0);
                chk("k2_ls", a_ls, 0);
                chk("k2_nextx", a_x, 2);
            end
            if (k == 640) begin
                chk("k640_blank_n", a_blank_n, 1);
                chk("k640_nextx", a_x, 0);
            end
            if (k == 641) chk("k641_blank_n", a_blank_n, 0);
            if (k == 700) chk("k700_vsync", a_vs, 1);
            if (k == 800) begin
                chk("k800_nextx", a_x, 0);
                chk("k800_nexty", a_y, 1);
                chk("k800_ls", a_ls, 0);
            end
            if (k == 801) begin
                chk("k801_ls", a_ls, 1);
                chk("k801_fs", a_fs, 0);
                chk("k801_nextx", a_x, 1);
                chk("k801_nexty", a_y, 1);
                chk("k801_blank_n", a_blank_n, 1);
            end
            if (k == 1056) chk("b_k1056_ls", b_ls, 0);
            if (k == 1057) chk("b_k1057_ls", b_ls, 1);
            if (k == 121) chk("c_k121_fs", c_fs, 1);

            if (a_hs == 1'b0) begin
                a_hs_low++;
                if (a_hs_first < 0) a_hs_first = k;
                a_hs_last = k;
            end
            if (a_ls) a_ls_cnt++;
            if (b_hs == 1'b1) begin
                b_hs_high++;
                if (b_hs_first < 0) b_hs_first = k;
                b_hs_last = k;
            end
            if (c_fs) c_fs_cnt++;
            if (c_ls) c_ls_cnt++;
            if (k <= 120 && c_vs == 1'b0) begin
                c_vs_low++;
                if (c_vs_first < 0) c_vs_first = k;
            end
        end
        chk("a_hs_low_cnt",  a_hs_low, 96);
        chk("a_hs_first",    a_hs_first, 657);
        chk("a_hs_last",     a_hs_last, 752);
        chk("a_ls_cnt",      a_ls_cnt, 2);
        chk("b_hs_high_cnt", b_hs_high, 128);
        chk("b_hs_first",    b_hs_first, 841);
        chk("b_hs_last",     b_hs_last, 968);
        chk("c_fs_cnt",      c_fs_cnt, 9);
        chk("c_ls_cnt",      c_ls_cnt, 71);
        chk("c_vs_low_cnt",  c_vs_low, 30);
        chk("c_vs_first",    c_vs_first, 76);

        // Alternating enable: A sits at (260,1), C at (10,6); C's line marker lands on the 6th enable
        for (int i = 0; i < 20; i++) begin
            PixelEn = (i % 2 == 0);
            tick();
            chk("tog_nextx", a_x, 260 + i / 2 + 1);
            chk("tog_c_ls", c_ls, (i == 10) ? 1 : 0);
            chk("tog_a_ls", a_ls, 0);
            if (c_ls) c_ls_pulses++;
        end
        chk("tog_c_ls_pulses", c_ls_pulses, 1);

        // Advance A to hCount 300, then reset between edges
        PixelEn = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        chk("pre_rst_nextx", a_x, 300);
        chk("pre_rst_blank_n", a_blank_n, 1);
        Reset = 1'b0;
        #1;
        chk("mid_rst_blank_n", a_blank_n, 0);
        chk("mid_rst_nextx", a_x, 0);
        chk("mid_rst_nexty", a_y, 0);
        chk("mid_rst_hsync_b", b_hs, 0);
        chk("mid_rst_ls", a_ls, 0);
        tick();
        chk("held_rst_nextx", a_x, 0);
        Reset = 1'b1;
        tick();
        chk("restart_fs", a_fs, 1);
        chk("restart_ls", a_ls, 1);
        chk("restart_nextx", a_x, 1);
        chk("restart_nexty", a_y, 0);
        chk("restart_blank_n", a_blank_n, 1);
        tick();
        chk("restart2_fs", a_fs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
